// File: rtl/fifo_push_arbiter_if.sv
// Requester/FIFO push bundle; arbiter connects through master, the environment through slave.
// Macro FIFO_PUSH_ARB_TAG_EN widens push_data_o by the requester index.
interface fifo_push_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32
);
    localparam int ID_W = $clog2(NUM_REQ);
`ifdef FIFO_PUSH_ARB_TAG_EN
    localparam int PUSH_W = DATA_WIDTH + 1 + ID_W;
`else
    localparam int PUSH_W = DATA_WIDTH + 1;
`endif

    logic [NUM_REQ-1:0]                  req_valid_i;
    logic [NUM_REQ*(DATA_WIDTH+1)-1:0]   req_data_i;
    logic [NUM_REQ-1:0]                  req_grant_o;
    logic                                push_valid_o;
    logic [PUSH_W-1:0]                   push_data_o;
    logic                                push_grant_i;
    logic [ID_W-1:0]                     owner_o;
    logic                                locked_o;

    modport master (
        input  req_valid_i, req_data_i, push_grant_i,
        output req_grant_o, push_valid_o, push_data_o, owner_o, locked_o
    );

    modport slave (
        output req_valid_i, req_data_i, push_grant_i,
        input  req_grant_o, push_valid_o, push_data_o, owner_o, locked_o
    );
endinterface

// File: rtl/fifo_push_arbiter.sv
// Round-robin arbiter sharing one FIFO push port, owner locked for up to MAX_BURST beats.
// Latency: zero-cycle combinational select/grant; state updates on transfer edges.
// Backpressure: push_grant_i low freezes grants, state, pointer and burst count. Macro: FIFO_PUSH_ARB_TAG_EN.
module fifo_push_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    fifo_push_arbiter_if.master bus
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam int DW1   = DATA_WIDTH + 1;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t            r_state;
    logic [ID_W-1:0]   r_owner;
    logic [ID_W-1:0]   r_rr_ptr;
    logic [CNT_W-1:0]  r_beat_cnt;

    logic              w_search_hit;
    logic [ID_W-1:0]   w_search_idx;
    logic [ID_W:0]     w_sum;
    logic [ID_W-1:0]   w_sel;
    logic              w_sel_any;
    logic              w_sel_req_vld;
    logic [DATA_WIDTH:0] w_sel_dat;
    logic              w_push_vld;
    logic              w_xfer;
    logic              w_owner_vld;

    function automatic logic [ID_W-1:0] next_idx(input logic [ID_W-1:0] x);
        return (x == ID_W'(NUM_REQ - 1)) ? '0 : x + 1'b1;
    endfunction

    // First valid requester at or after the round-robin pointer, wrapping.
    always_comb begin
        w_search_hit = 1'b0;
        w_search_idx = '0;
        w_sum        = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_sum = {1'b0, r_rr_ptr} + (ID_W+1)'(i);
            if (w_sum >= (ID_W+1)'(NUM_REQ))
                w_sum = w_sum - (ID_W+1)'(NUM_REQ);
            if (!w_search_hit && bus.req_valid_i[w_sum[ID_W-1:0]]) begin
                w_search_hit = 1'b1;
                w_search_idx = w_sum[ID_W-1:0];
            end
        end
    end

    assign w_sel     = (r_state == LOCKED) ? r_owner : w_search_idx;
    assign w_sel_any = (r_state == LOCKED) || w_search_hit;

    always_comb begin
        w_sel_req_vld = 1'b0;
        w_sel_dat     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_sel == ID_W'(k)) begin
                w_sel_req_vld = bus.req_valid_i[k];
                w_sel_dat     = bus.req_data_i[k*DW1 +: DW1];
            end
        end
    end

    // Outputs are gated by rst_n so they read zero for the whole reset window.
    assign w_push_vld  = rst_n && w_sel_any && w_sel_req_vld;
    assign w_xfer      = w_push_vld && bus.push_grant_i;
    assign w_owner_vld = w_sel_req_vld;

    always_comb begin
        bus.req_grant_o = '0;
        for (int k = 0; k < NUM_REQ; k++)
            bus.req_grant_o[k] = w_xfer && (w_sel == ID_W'(k));
    end

    assign bus.push_valid_o = w_push_vld;
`ifdef FIFO_PUSH_ARB_TAG_EN
    assign bus.push_data_o  = w_push_vld ? {w_sel, w_sel_dat} : '0;
`else
    assign bus.push_data_o  = w_push_vld ? w_sel_dat : '0;
`endif
    assign bus.owner_o      = (rst_n && w_sel_any) ? w_sel : '0;
    assign bus.locked_o     = (r_state == LOCKED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_owner    <= '0;
            r_rr_ptr   <= '0;
            r_beat_cnt <= '0;
        end else if (bus.push_grant_i) begin
            case (r_state)
                IDLE: begin
                    if (w_xfer) begin
                        if (MAX_BURST > 1) begin
                            r_state    <= LOCKED;
                            r_owner    <= w_sel;
                            r_beat_cnt <= CNT_W'(1);
                        end else begin
                            r_rr_ptr   <= next_idx(w_sel);
                        end
                    end
                end
                LOCKED: begin
                    // Owner dropping valid releases the port after one bubble.
                    if (!w_owner_vld || (r_beat_cnt + 1'b1 == CNT_W'(MAX_BURST))) begin
                        r_state    <= IDLE;
                        r_rr_ptr   <= next_idx(r_owner);
                        r_beat_cnt <= '0;
                    end else begin
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Directed bench: burst rotation, bubble release, FIFO-full hold, mid-burst reset, MAX_BURST=1, data/tag path.
module tb_fifo_push_arbiter;
    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;
    int   exp_k;
    logic [32:0] exp_dat;

    fifo_push_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(32)) bus1();
    fifo_push_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(32)) bus2();

    fifo_push_arbiter #(.NUM_REQ(4), .DATA_WIDTH(32), .MAX_BURST(4)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.master)
    );

    fifo_push_arbiter #(.NUM_REQ(4), .DATA_WIDTH(32), .MAX_BURST(1)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        bus1.req_valid_i  = 4'b1111;
        bus1.push_grant_i = 1'b1;
        for (int k = 0; k < 4; k++)
            bus1.req_data_i[k*33 +: 33] = {1'b1, 32'hA000_0000 + 32'(k)};
        bus2.req_valid_i  = 4'b0000;
        bus2.req_data_i   = '0;
        bus2.push_grant_i = 1'b1;
        #2;
        // Outputs held at zero during reset despite all requests valid
        check("rst_grant",  bus1.req_grant_o,  0);
        check("rst_pvld",   bus1.push_valid_o, 0);
        check("rst_pdat",   bus1.push_data_o,  0);
        check("rst_owner",  bus1.owner_o,      0);
        check("rst_locked", bus1.locked_o,     0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // All valid: four-beat bursts rotating 0,1,2,3,0
        for (int b = 0; b < 17; b++) begin
            exp_k   = (b / 4) % 4;
            exp_dat = {1'b1, 32'hA000_0000 + 32'(exp_k)};
            check("rot_grant",  bus1.req_grant_o,  64'(4'b0001 << exp_k));
            check("rot_data",   bus1.push_data_o[32:0], exp_dat);
            check("rot_locked", bus1.locked_o,     (b % 4) != 0);
            tick();
        end

        // Requester 2 alone for two beats then drops: bubble, search resumes at 3
        bus1.req_valid_i = 4'b0100;
        do_reset();
        check("b2_grant1",  bus1.req_grant_o, 4'b0100);
        check("b2_lock1",   bus1.locked_o,    0);
        tick();
        check("b2_grant2",  bus1.req_grant_o, 4'b0100);
        check("b2_lock2",   bus1.locked_o,    1);
        tick();
        bus1.req_valid_i = 4'b0000;
        #1;
        check("b2_bubble_g", bus1.req_grant_o,  0);
        check("b2_bubble_v", bus1.push_valid_o, 0);
        check("b2_bubble_l", bus1.locked_o,     1);
        tick();
        check("b2_released", bus1.locked_o,     0);
        bus1.req_valid_i = 4'b1010;
        #1;
        check("b2_next_g",   bus1.req_grant_o, 4'b1000);
        check("b2_next_own", bus1.owner_o,     3);

        // Owner 1 stalled by full FIFO at beat count 2
        bus1.req_valid_i = 4'b0110;
        do_reset();
        check("full_b1", bus1.req_grant_o, 4'b0010);
        tick();
        check("full_b2", bus1.req_grant_o, 4'b0010);
        tick();
        bus1.push_grant_i = 1'b0;
        #1;
        for (int c = 0; c < 5; c++) begin
            check("full_grant", bus1.req_grant_o,  0);
            check("full_owner", bus1.owner_o,      1);
            check("full_lock",  bus1.locked_o,     1);
            check("full_pvld",  bus1.push_valid_o, 1);
            tick();
        end
        bus1.push_grant_i = 1'b1;
        #1;
        check("full_b3", bus1.req_grant_o, 4'b0010);
        tick();
        check("full_b4", bus1.req_grant_o, 4'b0010);
        tick();
        check("full_rel_g",    bus1.req_grant_o, 4'b0100);
        check("full_rel_lock", bus1.locked_o,    0);

        // Reset in the middle of owner 3's burst
        bus1.req_valid_i = 4'b1000;
        do_reset();
        check("mid_b1", bus1.req_grant_o, 4'b1000);
        tick();
        check("mid_own", bus1.owner_o,  3);
        check("mid_lck", bus1.locked_o, 1);
        tick();
        #2;
        bus1.req_valid_i = 4'b1111;
        rst_n = 1'b0;
        #1;
        check("mid_rst_g",   bus1.req_grant_o,  0);
        check("mid_rst_v",   bus1.push_valid_o, 0);
        check("mid_rst_d",   bus1.push_data_o,  0);
        check("mid_rst_own", bus1.owner_o,      0);
        check("mid_rst_lck", bus1.locked_o,     0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("mid_restart", bus1.req_grant_o, 4'b0001);
        check("mid_restart_l", bus1.locked_o,  0);

        // MAX_BURST=1 instance alternates between requesters 0 and 3
        bus2.req_valid_i = 4'b1001;
        do_reset();
        for (int b = 0; b < 4; b++) begin
            exp_k = (b % 2 == 0) ? 0 : 3;
            check("mb1_grant",  bus2.req_grant_o, 64'(4'b0001 << exp_k));
            check("mb1_locked", bus2.locked_o,    0);
            tick();
        end

        // Data path (and tag field when built with FIFO_PUSH_ARB_TAG_EN)
        bus1.req_valid_i = 4'b0100;
        bus1.req_data_i[2*33 +: 33] = 33'h1_2345_6789;
        do_reset();
        check("dat_low", bus1.push_data_o[32:0], 33'h1_2345_6789);
`ifdef FIFO_PUSH_ARB_TAG_EN
        check("dat_tag", bus1.push_data_o[34:33], 2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/fifo_push_arbiter.md
FIFO_PUSH_ARBITER -- requirements
Module: fifo_push_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing one FIFO push port (2..16).
REQ-002 Parameter DATA_WIDTH, default 32; every data bus is DATA_WIDTH+1 bits wide, [DATA_WIDTH:0].
REQ-003 Parameter MAX_BURST, default 4, maximum consecutive beats one owner may push before forced release (1..255).
REQ-004 Derived widths: ID_W = $clog2(NUM_REQ), CNT_W = $clog2(MAX_BURST+1).
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 req_valid_i  input  NUM_REQ  bit k high: requester k holds a beat.
REQ-008 req_data_i  input  NUM_REQ*(DATA_WIDTH+1)  slice k is requester k data.
REQ-009 req_grant_o  output  NUM_REQ  bit k high: requester k beat accepted this cycle.
REQ-010 push_valid_o  output  1  to FIFO push_valid_i.
REQ-011 push_data_o  output  DATA_WIDTH+1 (+ID_W with tag)  to FIFO push_data_i.
REQ-012 push_grant_i  input  1  from FIFO push_grant_o; high means FIFO not full.
REQ-013 owner_o  output  ID_W  index of the currently selected requester; 0 when none.
REQ-014 locked_o  output  1  high while in state LOCKED.

Function
REQ-015 Beat transfer occurs on a rising edge where push_valid_o and push_grant_i are both high.
REQ-016 States: IDLE (no owner) and LOCKED (owner register holds requester index).
REQ-017 IDLE selection: the first k with req_valid_i[k] high, searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ; combinational, zero-cycle latency.
REQ-018 LOCKED selection: the owner register only; no other requester is granted.
REQ-019 push_valid_o = req_valid_i[selected]; push_data_o = req_data_i slice of selected; both 0 when nothing selected.
REQ-020 req_grant_o[k] = push_grant_i AND k is selected AND req_valid_i[k]; at most one bit high (one-hot or zero).
REQ-021 Requesters SHALL NOT make req_valid_i depend on req_grant_o; a beat once raised holds its data until granted.
REQ-022 IDLE transfer with MAX_BURST > 1: next state LOCKED, owner <= selected, beat_cnt <= 1.
REQ-023 IDLE transfer with MAX_BURST = 1: stay IDLE, rr_ptr <= selected+1 mod NUM_REQ; LOCKED is never entered.
REQ-024 LOCKED transfer: beat_cnt increments; if the new value equals MAX_BURST, next state IDLE, rr_ptr <= owner+1 mod NUM_REQ, beat_cnt <= 0.
REQ-025 LOCKED with owner req_valid_i low: no transfer that cycle, next state IDLE, rr_ptr <= owner+1 mod NUM_REQ, beat_cnt <= 0 (one bubble cycle).
REQ-026 FIFO full (push_grant_i low): no grant, no state, rr_ptr or beat_cnt change; owner retained.
REQ-027 rr_ptr wrap: NUM_REQ-1 + 1 yields 0.
REQ-028 No requester waits more than (NUM_REQ-1)*MAX_BURST transfers plus NUM_REQ-1 bubbles while asserting valid and FIFO accepts.

Reset
REQ-029 rst_n low SHALL asynchronously force state IDLE, rr_ptr 0, owner 0, beat_cnt 0.
REQ-030 While rst_n low: req_grant_o 0, push_valid_o 0, push_data_o 0, owner_o 0, locked_o 0.
REQ-031 Reset asserted mid-burst SHALL drop the burst; after release arbitration restarts from requester 0.

Configuration
REQ-032 Macro FIFO_PUSH_ARB_TAG_EN defined: push_data_o is DATA_WIDTH+1+ID_W bits, {selected index, data}, index in MSBs.
REQ-033 Macro undefined: push_data_o is DATA_WIDTH+1 bits of data only; all other behaviour identical.

Verification
REQ-034 NUM_REQ=4, MAX_BURST=4, all valid, push_grant_i=1 -> grants 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0...
REQ-035 Only req 2 valid for 2 beats then drops, push_grant_i=1 -> 2 beats granted, one bubble, locked_o falls, next grant searches from 3.
REQ-036 Owner 1 locked at beat_cnt 2, push_grant_i low 5 cycles -> no grants, owner_o=1 held, burst resumes with beats 3,4 then releases.
REQ-037 Reset pulsed mid-burst of owner 3 -> outputs 0 immediately; after release with all valid, first grant goes to requester 0.
REQ-038 MAX_BURST=1, req 0 and 3 valid -> grants alternate 0,3,0,3, locked_o never high.
REQ-039 TAG_EN build, req 2 pushes data 0x1_2345_6789 -> push_data_o MSB field 2, low field 0x1_2345_6789.
